// File: rtl/piezo_pkg.sv
// Shared definitions for the piezo tone generator.
//
// Contents:
//   tone_state_e   - controller states (IDLE, PLAY, RELEASE), 2-bit encoding
//   MIN_LIMIT_DEF  - default smallest half-period that still counts as a tone
//   CNT_W_DEF      - default counter / limit width
//   limitIsTone()  - helper deciding whether a divider limit is a playable tone
package piezo_pkg;

  // IDLE    : silent, waiting for a tone request
  // PLAY    : square wave running, retunes allowed at half-period boundaries
  // RELEASE : request gone, letting the wave finish low before going silent
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } tone_state_e;

  localparam int MIN_LIMIT_DEF = 2;
  localparam int CNT_W_DEF     = 32;

  // A limit below the minimum half-period is treated as a rest, so it never
  // produces a tone even when play enable is high.
  function automatic logic limitIsTone(input logic [CNT_W_DEF-1:0] limit,
                                       input logic [CNT_W_DEF-1:0] minLimit);
    return (limit >= minLimit);
  endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Piezo square-wave generator: sound end of the judgement path.
//
// Takes the play enable and divider limit from the judgement controller and
// drives the piezo pin with a glitch-free square wave. Pitch changes only
// take effect at half-period boundaries, and a stop lets the wave finish its
// current half-period so the pin always ends low without a runt pulse.
//
// Ports:
//   clk          in   1      system clock
//   rst          in   1      synchronous, active-high reset
//   i_play_en    in   1      level: tone requested
//   i_cnt_limit  in   CNT_W  half-period length in clk cycles
//   o_piezo      out  1      square wave to the piezo pin
//   o_busy       out  1      high whenever the generator is not IDLE
//   o_note_start out  1      one-cycle pulse after an IDLE->PLAY transition
//   o_cur_limit  out  CNT_W  half-period currently in use
module piezo_tone_gen
  import piezo_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MIN_LIMIT = MIN_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_play_en,
  input  logic [CNT_W-1:0] i_cnt_limit,
  output logic             o_piezo,
  output logic             o_busy,
  output logic             o_note_start,
  output logic [CNT_W-1:0] o_cur_limit
);

  localparam logic [CNT_W-1:0] MinLimitV = CNT_W'(MIN_LIMIT);
  localparam logic [CNT_W-1:0] OneV      = CNT_W'(1);

  tone_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic             piezo_q, piezo_d;
  logic             noteStart_q, noteStart_d;

  logic             req;
  logic             boundary;
  logic [CNT_W-1:0] cntNext;

  // A request needs both the enable and a limit long enough to be a tone;
  // anything shorter is a rest and behaves exactly like play enable low.
  assign req = i_play_en && (i_cnt_limit >= MinLimitV);

  // lim_q is never below MIN_LIMIT (>= 2) outside IDLE, so lim_q-1 cannot
  // underflow and the counter resets before it could ever wrap.
  assign boundary = (cnt_q == (lim_q - OneV));
  assign cntNext  = cnt_q + OneV;

  // State, counter, limit and output registers; reset wins even mid-tone.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lim_q       <= '0;
      piezo_q     <= 1'b0;
      noteStart_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lim_q       <= lim_d;
      piezo_q     <= piezo_d;
      noteStart_q <= noteStart_d;
    end
  end

  // Next-state logic. Boundaries toggle the pin and restart the count; the
  // limit is only reloaded at a boundary while still requested, so a pitch
  // change never shortens or stretches the half-period in progress.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lim_d       = lim_q;
    piezo_d     = piezo_q;
    noteStart_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        piezo_d = 1'b0;
        if (req) begin
          state_d     = PLAY;
          lim_d       = i_cnt_limit;
          piezo_d     = 1'b1;
          noteStart_d = 1'b1;
        end
      end

      PLAY: begin
        if (boundary) begin
          cnt_d   = '0;
          piezo_d = ~piezo_q;
          if (req) begin
            lim_d = i_cnt_limit;
          end
        end else begin
          cnt_d = cntNext;
        end
        // Losing the request still lets this edge's toggle happen; the
        // wave then drains in RELEASE.
        if (!req) begin
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        if (req) begin
          // Re-request resumes without touching the phase; the new limit
          // is picked up at the following boundary from PLAY.
          state_d = PLAY;
          if (boundary) begin
            cnt_d   = '0;
            piezo_d = ~piezo_q;
          end else begin
            cnt_d = cntNext;
          end
        end else if (boundary) begin
          // Whether the pin was high (falling edge now) or already low
          // (low half-period just finished), end silent and low.
          cnt_d   = '0;
          piezo_d = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cntNext;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        piezo_d = 1'b0;
      end
    endcase
  end

  assign o_piezo      = piezo_q;
  assign o_busy       = (state_q != IDLE);
  assign o_note_start = noteStart_q;
  assign o_cur_limit  = lim_q;

endmodule

// File: tb/tb_piezo_tone_gen.sv
// Directed scoreboard bench for piezo_tone_gen.
//
// Expected per-cycle outputs are queued as stimulus is planned and popped one
// per clock, 1 time unit after the rising edge, for comparison.
module tb_piezo_tone_gen;
  import piezo_pkg::*;

  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic             i_play_en;
  logic [CNT_W-1:0] i_cnt_limit;
  logic             o_piezo;
  logic             o_busy;
  logic             o_note_start;
  logic [CNT_W-1:0] o_cur_limit;

  typedef struct {
    logic             piezo;
    logic             busy;
    logic             noteStart;
    logic [CNT_W-1:0] limit;
    string            tag;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  piezo_tone_gen #(.CNT_W(CNT_W), .MIN_LIMIT(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_play_en    (i_play_en),
    .i_cnt_limit  (i_cnt_limit),
    .o_piezo      (o_piezo),
    .o_busy       (o_busy),
    .o_note_start (o_note_start),
    .o_cur_limit  (o_cur_limit)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the inputs seen by the next rising edge.
  task automatic applyStimulus(input logic r, input logic play, input int limit);
    rst         = r;
    i_play_en   = play;
    i_cnt_limit = CNT_W'(limit);
  endtask

  // Queue n identical expected output cycles.
  task automatic pushExp(input int n, input logic p, input logic b, input logic ns,
                         input int limit, input string tag);
    exp_t e;
    e.piezo     = p;
    e.busy      = b;
    e.noteStart = ns;
    e.limit     = CNT_W'(limit);
    e.tag       = tag;
    for (int i = 0; i < n; i++) expQ.push_back(e);
  endtask

  // Advance one clock and compare the DUT against the oldest expectation.
  task automatic checkOutput();
    exp_t e;
    logic [CNT_W+2:0] obs, req;
    @(posedge clk);
    #1;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty observed no expectation required one at %0t", $time);
    end else begin
      e   = expQ.pop_front();
      obs = {o_piezo, o_busy, o_note_start, o_cur_limit};
      req = {e.piezo, e.busy, e.noteStart, e.limit};
      assert (obs === req) else begin
        errors++;
        $error("[TB] FAIL %s observed piezo=%b busy=%b start=%b lim=%0d required piezo=%b busy=%b start=%b lim=%0d at %0t",
               e.tag, o_piezo, o_busy, o_note_start, o_cur_limit,
               e.piezo, e.busy, e.noteStart, e.limit, $time);
      end
    end
  endtask

  // Run all queued expectations.
  task automatic drain();
    int n;
    n = expQ.size();
    for (int i = 0; i < n; i++) checkOutput();
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 0);

    // Reset state
    pushExp(1, 0, 0, 0, 0, "reset");
    drain();

    // Start with limit 4: rise one cycle after request, 4 high / 4 low, one start pulse
    applyStimulus(1'b0, 1'b1, 4);
    pushExp(1, 1, 1, 1, 4, "t1_start");
    pushExp(3, 1, 1, 0, 4, "t1_high");
    pushExp(4, 0, 1, 0, 4, "t1_low");
    pushExp(1, 1, 1, 0, 4, "t1_rise2");
    drain();

    // Retune 4->6 one cycle into a high phase: high stays 4, then 6/6
    applyStimulus(1'b0, 1'b1, 6);
    pushExp(3, 1, 1, 0, 4, "t2_high_old");
    pushExp(6, 0, 1, 0, 6, "t2_low_new");
    pushExp(6, 1, 1, 0, 6, "t2_high_new");
    drain();

    // Reset mid-PLAY with pin high
    applyStimulus(1'b1, 1'b1, 6);
    pushExp(1, 0, 0, 0, 0, "t6_reset_mid");
    drain();
    applyStimulus(1'b0, 1'b0, 6);
    pushExp(1, 0, 0, 0, 0, "t6_idle");
    drain();

    // Stop one cycle into a high phase: high completes, busy drops at fall
    applyStimulus(1'b0, 1'b1, 4);
    pushExp(1, 1, 1, 1, 4, "t3_start");
    drain();
    applyStimulus(1'b0, 1'b0, 4);
    pushExp(3, 1, 1, 0, 4, "t3_drain_high");
    pushExp(2, 0, 0, 0, 4, "t3_stopped");
    drain();

    // Stop then re-request during RELEASE: seamless, no start pulse
    applyStimulus(1'b0, 1'b1, 4);
    pushExp(1, 1, 1, 1, 4, "t4_start");
    drain();
    applyStimulus(1'b0, 1'b0, 4);
    pushExp(1, 1, 1, 0, 4, "t4_release");
    drain();
    applyStimulus(1'b0, 1'b1, 4);
    pushExp(2, 1, 1, 0, 4, "t4_resume_high");
    pushExp(4, 0, 1, 0, 4, "t4_resume_low");
    pushExp(1, 1, 1, 0, 4, "t4_resume_rise");
    drain();

    // Rest limit during PLAY acts as a stop
    applyStimulus(1'b0, 1'b1, 1);
    pushExp(3, 1, 1, 0, 4, "t5_rest_drain");
    pushExp(1, 0, 0, 0, 4, "t5_rest_stop");
    drain();

    // Rest limits from IDLE never start a tone
    applyStimulus(1'b0, 1'b1, 0);
    pushExp(2, 0, 0, 0, 4, "t5_limit0_idle");
    drain();
    applyStimulus(1'b0, 1'b1, 1);
    pushExp(2, 0, 0, 0, 4, "t5_limit1_idle");
    drain();

    // Stop during a low phase: finish low, no extra rise, then IDLE
    applyStimulus(1'b0, 1'b1, 4);
    pushExp(1, 1, 1, 1, 4, "low_stop_start");
    pushExp(3, 1, 1, 0, 4, "low_stop_high");
    pushExp(1, 0, 1, 0, 4, "low_stop_fall");
    drain();
    applyStimulus(1'b0, 1'b0, 4);
    pushExp(3, 0, 1, 0, 4, "low_stop_drain");
    pushExp(2, 0, 0, 0, 4, "low_stop_idle");
    drain();

    // Minimum legal limit of 2
    applyStimulus(1'b0, 1'b1, 2);
    pushExp(1, 1, 1, 1, 2, "min_start");
    pushExp(1, 1, 1, 0, 2, "min_high");
    pushExp(2, 0, 1, 0, 2, "min_low");
    pushExp(2, 1, 1, 0, 2, "min_high2");
    drain();

    applyStimulus(1'b1, 1'b0, 0);
    pushExp(1, 0, 0, 0, 0, "final_reset");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
